// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
//   Shared geometry, constants and FSM encoding for the instruction cache
//   responder. Direct-mapped, 64 lines of 16 bytes each, 64-bit addresses.
//   Address split: [63:10] tag | [9:4] index | [3:2] word offset | [1:0] byte.
// ---------------------------------------------------------------------------
package icache_pkg;

    localparam int ICACHE_LINES       = 64;
    localparam int ICACHE_BLOCK_BYTES = 16;

    localparam int ADDR_W      = 64;
    localparam int INSN_W      = 32;
    localparam int BLOCK_W     = ICACHE_BLOCK_BYTES * 8;        // 128
    localparam int WORDS       = BLOCK_W / INSN_W;              // 4
    localparam int BLOCK_OFF_W = $clog2(ICACHE_BLOCK_BYTES);    // 4
    localparam int OFFSET_W    = $clog2(WORDS);                 // 2
    localparam int INDEX_W     = $clog2(ICACHE_LINES);          // 6
    localparam int TAG_LSB     = BLOCK_OFF_W + INDEX_W;         // 10
    localparam int TAG_W       = ADDR_W - TAG_LSB;              // 54

    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_line_ram.sv
// ---------------------------------------------------------------------------
// icache_line_ram
//   Tag + data storage for the direct-mapped instruction cache.
//   64 entries of {54-bit tag, 128-bit block}; asynchronous read so a hit
//   resolves in the same cycle, synchronous single-port write for refills.
//   Valid bits are kept by the parent so they can be flushed in one edge.
// Ports:
//   CLK      - clock
//   i_we     - write enable (refill)
//   i_waddr  - line index to write
//   i_wtag   - tag written with the line
//   i_wdata  - refill block, word 0 in bits [31:0]
//   i_raddr  - line index to read
//   o_rtag   - tag stored at i_raddr
//   o_rdata  - block stored at i_raddr
// ---------------------------------------------------------------------------
module icache_line_ram
    import icache_pkg::*;
(
    input  logic               CLK,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_waddr,
    input  logic [TAG_W-1:0]   i_wtag,
    input  logic [BLOCK_W-1:0] i_wdata,
    input  logic [INDEX_W-1:0] i_raddr,
    output logic [TAG_W-1:0]   o_rtag,
    output logic [BLOCK_W-1:0] o_rdata
);

    logic [TAG_W-1:0]   r_tag_mem  [ICACHE_LINES];
    logic [BLOCK_W-1:0] r_data_mem [ICACHE_LINES];

    // NOTE: the arrays carry no reset; an entry is only trusted once the
    // parent's valid bit is set, so clearing them would be pure cost.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_tag_mem[i_waddr]  <= i_wtag;
            r_data_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rtag  = r_tag_mem[i_raddr];
    assign o_rdata = r_data_mem[i_raddr];

endmodule

// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder
//   Read-only direct-mapped instruction cache front end. Hits answer in the
//   same cycle; a miss issues one registered refill request and waits for
//   MEM_ACK. FENCE_I flushes all lines and poisons any refill in flight.
// Ports:
//   CLK, reset   - clock, synchronous active-high reset
//   FE_PC/FE_REQ - fetch address and request from the fetch stage
//   FENCE_I      - one-cycle flush pulse
//   cache_hit    - combinational hit for FE_PC
//   instruction  - combinational instruction word (NOP when no hit)
//   MEM_REQ/ADDR - registered refill request and 16-byte aligned address
//   MEM_ACK      - refill data valid on MEM_RDATA this cycle
//   MEM_RDATA    - refill block, word 0 in bits [31:0]
//   MISS_CNT     - saturating count of refills started
// ---------------------------------------------------------------------------
module icache_responder
    import icache_pkg::*;
(
    input  logic               CLK,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  FE_PC,
    input  logic               FE_REQ,
    input  logic               FENCE_I,
    output logic               cache_hit,
    output logic [INSN_W-1:0]  instruction,
    output logic               MEM_REQ,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    input  logic               MEM_ACK,
    input  logic [BLOCK_W-1:0] MEM_RDATA,
    output logic [31:0]        MISS_CNT
);

    icache_state_e r_state;
    icache_state_e w_state_next;

    logic                    r_mem_req;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [31:0]             r_miss_cnt;
    logic                    r_discard;
    logic [ICACHE_LINES-1:0] r_valid;

    logic [TAG_W-1:0]             w_tag;
    logic [INDEX_W-1:0]           w_index;
    logic [OFFSET_W-1:0]          w_offset;
    logic                         w_aligned;
    logic [TAG_W-1:0]             w_rd_tag;
    logic [BLOCK_W-1:0]           w_rd_data;
    logic [WORDS-1:0][INSN_W-1:0] w_rd_words;
    logic                         w_hit;
    logic                         w_miss_start;
    logic                         w_fill_done;
    logic                         w_fill_we;

    assign w_tag     = FE_PC[ADDR_W-1:TAG_LSB];
    assign w_index   = FE_PC[TAG_LSB-1:BLOCK_OFF_W];
    assign w_offset  = FE_PC[BLOCK_OFF_W-1:2];
    assign w_aligned = (FE_PC[1:0] == 2'b00);

    icache_line_ram u_line_ram (
        .CLK     (CLK),
        .i_we    (w_fill_we),
        .i_waddr (r_mem_addr[TAG_LSB-1:BLOCK_OFF_W]),
        .i_wtag  (r_mem_addr[ADDR_W-1:TAG_LSB]),
        .i_wdata (MEM_RDATA),
        .i_raddr (w_index),
        .o_rtag  (w_rd_tag),
        .o_rdata (w_rd_data)
    );

    assign w_rd_words = w_rd_data;

    // A flush pulse masks the hit in its own cycle, so the fetch stage never
    // consumes a line that is being invalidated at this edge.
    assign w_hit = FE_REQ && (r_state == ST_IDLE) && r_valid[w_index] &&
                   (w_rd_tag == w_tag) && w_aligned && !FENCE_I;

    assign w_miss_start = FE_REQ && (r_state == ST_IDLE) && !w_hit &&
                          w_aligned && !FENCE_I;

    assign w_fill_done = (r_state == ST_WAIT) && MEM_ACK;

    // FENCE_I on the acknowledge cycle itself must also drop the data; the
    // discard flag would only take effect one edge too late.
    assign w_fill_we = w_fill_done && !r_discard && !FENCE_I;

    assign cache_hit   = w_hit;
    assign instruction = w_hit ? w_rd_words[w_offset] : NOP_INSN;
    assign MEM_REQ     = r_mem_req;
    assign MEM_ADDR    = r_mem_addr;
    assign MISS_CNT    = r_miss_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_miss_start) w_state_next = ST_WAIT;
            ST_WAIT: if (MEM_ACK)      w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_miss_cnt <= '0;
            r_discard  <= 1'b0;
            r_valid    <= '0;
        end else begin
            if (w_miss_start) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= {FE_PC[ADDR_W-1:BLOCK_OFF_W], {BLOCK_OFF_W{1'b0}}};
                if (r_miss_cnt != 32'hFFFF_FFFF) begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end else if (w_fill_done) begin
                r_mem_req <= 1'b0;
            end

            if (w_fill_done) begin
                r_discard <= 1'b0;
            end else if ((r_state == ST_WAIT) && FENCE_I) begin
                r_discard <= 1'b1;
            end

            if (FENCE_I) begin
                r_valid <= '0;
            end else if (w_fill_we) begin
                r_valid[r_mem_addr[TAG_LSB-1:BLOCK_OFF_W]] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// ---------------------------------------------------------------------------
// tb_icache_responder
//   Directed stimulus with a scoreboard: the stimulus pushes expected hits
//   and expected refill requests into queues; a monitor pops and compares
//   whenever the DUT raises cache_hit or starts a new MEM_REQ.
// ---------------------------------------------------------------------------
module tb_icache_responder;

    logic         CLK = 1'b0;
    logic         reset;
    logic [63:0]  FE_PC;
    logic         FE_REQ;
    logic         FENCE_I;
    logic         cache_hit;
    logic [31:0]  instruction;
    logic         MEM_REQ;
    logic [63:0]  MEM_ADDR;
    logic         MEM_ACK;
    logic [127:0] MEM_RDATA;
    logic [31:0]  MISS_CNT;

    icache_responder dut (
        .CLK         (CLK),
        .reset       (reset),
        .FE_PC       (FE_PC),
        .FE_REQ      (FE_REQ),
        .FENCE_I     (FENCE_I),
        .cache_hit   (cache_hit),
        .instruction (instruction),
        .MEM_REQ     (MEM_REQ),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_ACK     (MEM_ACK),
        .MEM_RDATA   (MEM_RDATA),
        .MISS_CNT    (MISS_CNT)
    );

    always #5 CLK = ~CLK;

    localparam logic [127:0] D1 = 128'h00000513_00000293_00000033_00100093;
    localparam logic [127:0] D2 = 128'h0040006F_FFF10113_00A00593_00B50533;
    localparam logic [127:0] D3 = 128'h30200073_00008067_0000100F_00C58633;
    localparam logic [31:0]  NOP = 32'h0000_0013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
    } hit_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] cnt;
    } refill_t;

    hit_t    hit_q[$];
    refill_t refill_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor.
    logic prev_req = 1'b0;
    initial begin
        hit_t    h;
        refill_t r;
        forever begin
            @(negedge CLK);
            if (cache_hit === 1'b1) begin
                if (hit_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_hit: pc %0h insn %0h, none expected", FE_PC, instruction);
                end else begin
                    h = hit_q.pop_front();
                    check("hit_pc", FE_PC, h.pc);
                    check("hit_insn", instruction, h.insn);
                end
            end
            if (MEM_REQ === 1'b1 && prev_req !== 1'b1) begin
                if (refill_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_refill: addr %0h, none expected", MEM_ADDR);
                end else begin
                    r = refill_q.pop_front();
                    check("refill_addr", MEM_ADDR, r.addr);
                    check("refill_miss_cnt", MISS_CNT, r.cnt);
                end
            end
            prev_req = MEM_REQ;
        end
    end

    // Miss on pc, hold for `waits` cycles, acknowledge with data. FENCE_I is
    // pulsed in WAIT cycle `fence_cyc` (== waits means the ack cycle; -1 none).
    // Junk fetches during WAIT must be ignored. Returns at posedge+1 of the
    // first IDLE cycle after the acknowledge.
    task automatic miss_and_fill(input logic [63:0] pc, input logic [127:0] data,
                                 input logic [31:0] cnt, input int waits,
                                 input int fence_cyc);
        refill_t r;
        r.addr = {pc[63:4], 4'h0};
        r.cnt  = cnt;
        FE_REQ = 1'b1;
        FE_PC  = pc;
        refill_q.push_back(r);
        @(negedge CLK);
        check("miss_no_hit", cache_hit, 1'b0);
        step();
        FE_PC = 64'h0000_ABCD_0000;
        for (int i = 0; i <= waits; i++) begin
            if (i == fence_cyc) FENCE_I = 1'b1;
            if (i == waits) begin
                MEM_ACK   = 1'b1;
                MEM_RDATA = data;
            end
            @(negedge CLK);
            check("wait_req_held", MEM_REQ, 1'b1);
            check("wait_addr_held", MEM_ADDR, r.addr);
            step();
            FENCE_I   = 1'b0;
            MEM_ACK   = 1'b0;
            MEM_RDATA = '0;
        end
        FE_REQ = 1'b0;
    endtask

    task automatic expect_hit(input logic [63:0] pc, input logic [31:0] insn);
        hit_t h;
        h.pc   = pc;
        h.insn = insn;
        hit_q.push_back(h);
        FE_REQ = 1'b1;
        FE_PC  = pc;
        @(negedge CLK);
        check("hit_seen", cache_hit, 1'b1);
        step();
        FE_REQ = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mis_pcs [3];
        mis_pcs[0] = 64'h3012;
        mis_pcs[1] = 64'h1002;
        mis_pcs[2] = 64'h3011;

        reset = 1'b1; FE_PC = '0; FE_REQ = 1'b0; FENCE_I = 1'b0;
        MEM_ACK = 1'b0; MEM_RDATA = '0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge CLK);
        check("rst_mem_req", MEM_REQ, 1'b0);
        check("rst_mem_addr", MEM_ADDR, 64'h0);
        check("rst_miss_cnt", MISS_CNT, 32'h0);
        check("rst_hit", cache_hit, 1'b0);
        check("rst_insn_nop", instruction, NOP);
        step();

        // First miss, 3 wait cycles, then hits on the filled line.
        miss_and_fill(64'h1000, D1, 32'd1, 3, -1);
        expect_hit(64'h1004, 32'h00000033);
        expect_hit(64'h1000, 32'h00100093);
        expect_hit(64'h100C, 32'h00000513);

        // Conflict on index 0: 0x1400 evicts 0x1000, which then misses again.
        miss_and_fill(64'h1400, D2, 32'd2, 1, -1);
        expect_hit(64'h1408, 32'hFFF10113);
        miss_and_fill(64'h1000, D1, 32'd3, 0, -1);
        @(negedge CLK);
        check("conflict_miss_cnt", MISS_CNT, 32'd3);
        step();
        expect_hit(64'h1008, 32'h00000293);

        // FENCE_I mid-WAIT drops the refill; the line misses again afterwards.
        miss_and_fill(64'h2000, D3, 32'd4, 2, 1);
        miss_and_fill(64'h2000, D3, 32'd5, 0, -1);
        expect_hit(64'h2004, 32'h0000100F);

        // FENCE_I on the acknowledge cycle also drops the refill.
        miss_and_fill(64'h3010, D2, 32'd6, 1, 1);
        miss_and_fill(64'h3010, D2, 32'd7, 0, -1);
        expect_hit(64'h301C, 32'h0040006F);

        // FENCE_I with a resident fetch in IDLE: flush only, no refill.
        FE_REQ = 1'b1; FE_PC = 64'h3010; FENCE_I = 1'b1;
        @(negedge CLK);
        check("fence_idle_no_hit", cache_hit, 1'b0);
        step();
        FE_REQ = 1'b0; FENCE_I = 1'b0;
        @(negedge CLK);
        check("fence_idle_no_req", MEM_REQ, 1'b0);
        check("fence_idle_cnt", MISS_CNT, 32'd7);
        step();
        miss_and_fill(64'h3010, D2, 32'd8, 0, -1);
        expect_hit(64'h3014, 32'h00A00593);

        // Misaligned fetches: no hit (even on a resident line), NOP, no refill.
        for (int i = 0; i < 3; i++) begin
            FE_REQ = 1'b1; FE_PC = mis_pcs[i];
            @(negedge CLK);
            check("misaligned_no_hit", cache_hit, 1'b0);
            check("misaligned_nop", instruction, NOP);
            step();
            FE_REQ = 1'b0;
            @(negedge CLK);
            check("misaligned_no_req", MEM_REQ, 1'b0);
            step();
        end

        // Reset during WAIT, then a stray MEM_ACK.
        begin
            refill_t r;
            r.addr = 64'h4000;
            r.cnt  = 32'd9;
            refill_q.push_back(r);
        end
        FE_REQ = 1'b1; FE_PC = 64'h4000;
        step();
        FE_REQ = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        MEM_ACK = 1'b1; MEM_RDATA = D1;
        @(negedge CLK);
        check("wait_rst_req", MEM_REQ, 1'b0);
        check("wait_rst_cnt", MISS_CNT, 32'd0);
        step();
        MEM_ACK = 1'b0; MEM_RDATA = '0;
        @(negedge CLK);
        check("stray_ack_req", MEM_REQ, 1'b0);
        step();
        miss_and_fill(64'h4000, D1, 32'd1, 0, -1);
        miss_and_fill(64'h3010, D2, 32'd2, 0, -1);
        expect_hit(64'h4008, 32'h00000293);

        step();
        check("hit_queue_drained", hit_q.size(), 0);
        check("refill_queue_drained", refill_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 CLK  input  1  clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high.
REQ-003 FE_PC  input  64  fetch address from the fetch stage.
REQ-004 FE_REQ  input  1  fetch stage requests an instruction at FE_PC this cycle.
REQ-005 FENCE_I  input  1  one-cycle pulse; invalidates all lines.
REQ-006 cache_hit  output  1  instruction is valid for the current FE_PC; combinational.
REQ-007 instruction  output  32  instruction word for FE_PC; combinational; 32'h00000013 (NOP) when cache_hit=0.
REQ-008 MEM_REQ  output  1  refill request to the backing memory; registered.
REQ-009 MEM_ADDR  output  64  refill block address, 16-byte aligned; registered.
REQ-010 MEM_ACK  input  1  memory returns MEM_RDATA this cycle.
REQ-011 MEM_RDATA  input  128  refill block; word 0 in bits [31:0].
REQ-012 MISS_CNT  output  32  count of refills started; saturates at 32'hFFFFFFFF.

Function
REQ-013 Direct-mapped, 64 lines x 16 bytes: offset FE_PC[3:2], index FE_PC[9:4], tag FE_PC[63:10] (54 bits).
REQ-014 cache_hit = FE_REQ && state==IDLE && valid[index] && tag[index]==FE_PC[63:10] && FE_PC[1:0]==0 && !FENCE_I.
REQ-015 Hit latency 0 cycles: instruction = data[index] word FE_PC[3:2] in the same cycle.
REQ-016 FSM states IDLE, WAIT; reset state IDLE.
REQ-017 IDLE -> WAIT when FE_REQ && !cache_hit && FE_PC[1:0]==0 && !FENCE_I; at that edge MEM_REQ<=1, MEM_ADDR<={FE_PC[63:4],4'b0}, MISS_CNT increments (saturating).
REQ-018 WAIT: MEM_REQ and MEM_ADDR held stable until MEM_ACK is sampled high.
REQ-019 WAIT with MEM_ACK=1: at that edge write line (data=MEM_RDATA, tag=MEM_ADDR[63:10], valid=1) unless the discard flag is set; MEM_REQ<=0; state -> IDLE.
REQ-020 A hit on the refilled address occurs at the earliest in the cycle after MEM_ACK (refill-to-hit 1 cycle).
REQ-021 FE_PC changes during WAIT are ignored; the refill for the captured MEM_ADDR always completes.
REQ-022 FENCE_I in any state clears all 64 valid bits at the edge; FENCE_I in WAIT (including the MEM_ACK cycle) sets the discard flag so that refill data is dropped; flag clears on return to IDLE.
REQ-023 FENCE_I and a miss in the same IDLE cycle: flush only, no refill started.
REQ-024 Misaligned FE_PC (FE_PC[1:0]!=0): cache_hit=0, no refill; fetch stage owns the fault.
REQ-025 Refill writing an index overwrites the previous line (no write-back, read-only cache).

Reset
REQ-026 reset: state=IDLE, MEM_REQ=0, MEM_ADDR=0, MISS_CNT=0, discard flag=0, all valid bits=0; tag/data arrays not reset.
REQ-027 reset in WAIT abandons the refill; a late MEM_ACK after reset is ignored.

Structure
REQ-028 Shared package icache_pkg holds ICACHE_LINES=64, ICACHE_BLOCK_BYTES=16, index/tag/offset widths, NOP_INSN=32'h00000013, and the FSM state encoding.
REQ-029 One sub-module icache_line_ram: 64 x (54-bit tag + 128-bit data), asynchronous read, synchronous single-port write; valid bits live in icache_responder.

Verification
REQ-030 After reset, FE_REQ=1, FE_PC=64'h1000 -> cache_hit=0; next cycle MEM_REQ=1, MEM_ADDR=64'h1000, MISS_CNT=1.
REQ-031 MEM_ACK=1 after 3 wait cycles with MEM_RDATA=128'h...00000033_00100093 -> next cycle FE_PC=64'h1004 gives cache_hit=1, instruction=32'h00000033; FE_PC=64'h1000 gives 32'h00100093.
REQ-032 Line 64'h1000 resident, FE_PC=64'h1400 (same index, different tag) -> miss, refill overwrites; then FE_PC=64'h1000 misses again, MISS_CNT=3.
REQ-033 FENCE_I during WAIT for 64'h2000, then MEM_ACK -> line not written; FE_PC=64'h2000 misses again afterward.
REQ-034 reset asserted during WAIT, stray MEM_ACK the next cycle -> MEM_REQ=0, no line valid, MISS_CNT=0.
REQ-035 FE_PC=64'h1002 with FE_REQ=1 -> cache_hit=0, instruction=32'h00000013, MEM_REQ stays 0.
